// File: rtl/cpu_pkg.sv
// Shared CPU decode types: immediate select codes,
// opcodes, decoded-entry bundle and skid buffer states.
package cpu_pkg;

  typedef enum logic [1:0] {
    NONE      = 2'b00,
    FOURBIT   = 2'b01,
    EIGHTBIT  = 2'b10,
    TWELVEBIT = 2'b11
  } sel_t;

  typedef enum logic [3:0] {
    OP_RTYPE = 4'h0,
    OP_BLT   = 4'h4,
    OP_BGT   = 4'h5,
    OP_BEQ   = 4'h6,
    OP_LW    = 4'h8,
    OP_SW    = 4'h9,
    OP_JMP   = 4'hC,
    OP_HALT  = 4'hF
  } opcode_t;

  typedef struct packed {
    sel_t        sel;
    logic [11:0] field;
    logic [3:0]  opcode;
    logic        illegal;
  } entry_t;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_t;

  function automatic entry_t decode_instr(
    input logic [15:0] instr
  );
    entry_t e;
    e         = '0;
    e.sel     = NONE;
    e.opcode  = instr[15:12];
    case (instr[15:12])
      OP_RTYPE, OP_HALT: begin
        e.sel = NONE;
      end
      OP_LW, OP_SW: begin
        e.sel   = FOURBIT;
        e.field = {8'h00, instr[3:0]};
      end
      OP_BLT, OP_BGT, OP_BEQ: begin
        e.sel   = EIGHTBIT;
        e.field = {4'h0, instr[7:0]};
      end
      OP_JMP: begin
        e.sel   = TWELVEBIT;
        e.field = instr[11:0];
      end
      default: begin
        e.illegal = 1'b1;
      end
    endcase
    return e;
  endfunction

endpackage

// File: rtl/decode_skid_buf.sv
// Two-entry valid/ready skid buffer with a registered
// ready so downstream stalls never reach upstream comb.
module decode_skid_buf
  import cpu_pkg::*;
#(
  parameter type T = entry_t
) (
  input  logic clk,
  input  logic rst,
  input  logic i_flush,
  input  logic i_valid,
  input  T     i_data,
  input  logic i_block_nxt,
  output logic o_ready,
  output logic o_valid,
  output T     o_data,
  input  logic i_ready
);

  buf_state_t r_state;
  buf_state_t w_state_nxt;
  T           r_head;
  T           r_skid;
  logic       r_ready;
  logic       w_acc;
  logic       w_con;
  logic       w_head_ld;
  logic       w_head_skid;
  logic       w_skid_ld;

  assign w_acc   = i_valid & r_ready;
  assign o_valid = (r_state != BUF_EMPTY);
  assign w_con   = o_valid & i_ready;
  assign o_ready = r_ready;
  assign o_data  = r_head;

  // Occupancy transitions; flush overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    w_head_ld   = 1'b0;
    w_head_skid = 1'b0;
    w_skid_ld   = 1'b0;
    unique case (r_state)
      BUF_EMPTY: begin
        if (w_acc) begin
          w_state_nxt = BUF_ONE;
          w_head_ld   = 1'b1;
        end
      end
      BUF_ONE: begin
        if (w_acc && w_con) begin
          w_head_ld = 1'b1;
        end else if (w_acc) begin
          w_state_nxt = BUF_FULL;
          w_skid_ld   = 1'b1;
        end else if (w_con) begin
          w_state_nxt = BUF_EMPTY;
        end
      end
      BUF_FULL: begin
        if (w_con) begin
          w_state_nxt = BUF_ONE;
          w_head_skid = 1'b1;
        end
      end
      default: begin
        w_state_nxt = BUF_EMPTY;
      end
    endcase
    if (i_flush) begin
      w_state_nxt = BUF_EMPTY;
      w_head_ld   = 1'b0;
      w_head_skid = 1'b0;
      w_skid_ld   = 1'b0;
    end
  end

  // State, storage and the registered ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= BUF_EMPTY;
      r_ready <= 1'b1;
      r_head  <= T'('0);
      r_skid  <= T'('0);
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt != BUF_FULL)
               & ~i_block_nxt;
      if (w_head_ld) begin
        r_head <= i_data;
      end else if (w_head_skid) begin
        r_head <= r_skid;
      end
      if (w_skid_ld) begin
        r_skid <= i_data;
      end
    end
  end

endmodule

// File: rtl/imm_field_decoder.sv
// Registered immediate-field decode stage feeding the
// sign extender: decode, halt latch, accept counter.
module imm_field_decoder
  import cpu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [15:0]      in_instr,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_sel,
  output logic [11:0]      out_field,
  output logic [3:0]       out_opcode,
  output logic             out_illegal,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  logic             r_halted;
  logic [CNT_W-1:0] r_count;
  logic             w_accept;
  logic             w_halt_nxt;
  entry_t           w_dec;
  entry_t           w_head;

  assign w_accept   = in_valid & in_ready;
  assign w_dec      = decode_instr(in_instr);
  assign w_halt_nxt = r_halted
                    | (w_accept
                       & (in_instr[15:12] == OP_HALT));

  // Sticky halt latch and wrapping accept counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_halted <= 1'b0;
      r_count  <= '0;
    end else begin
      r_halted <= w_halt_nxt;
      if (w_accept) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  decode_skid_buf #(
    .T(entry_t)
  ) u_buf (
    .clk         (clk),
    .rst         (rst),
    .i_flush     (flush),
    .i_valid     (in_valid),
    .i_data      (w_dec),
    .i_block_nxt (w_halt_nxt),
    .o_ready     (in_ready),
    .o_valid     (out_valid),
    .o_data      (w_head),
    .i_ready     (out_ready)
  );

  assign out_sel     = w_head.sel;
  assign out_field   = w_head.field;
  assign out_opcode  = w_head.opcode;
  assign out_illegal = w_head.illegal;
  assign halted      = r_halted;
  assign instr_count = r_count;

endmodule
